// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl
// Boot sequencer for a small CPU: streams an instruction image and a data image
// into the CPU memories through their external ports, runs the CPU for a fixed
// cycle budget, optionally dumps data memory back out, then pulses done.
//
// Optional feature macro: CPU_BOOT_DUMP_EN
//    defined   -> DUMP phase streams data memory words out on out_*.
//    undefined -> no DUMP state; RUN goes straight to DONE; out_valid,
//                 out_data, ren_ext_2 and the read path are tied to 0.
//
// Ports
//    clk, arst_n          clock, asynchronous active-low reset
//    start                launch pulse, only honoured in IDLE
//    imem_len, dmem_len   image word counts (saturated to memory depth)
//    run_cycles           number of cycles the CPU enable stays high
//    in_valid/in_ready/in_data      image load stream (IMEM words, then DMEM)
//    out_valid/out_ready/out_data   data-memory dump stream
//    addr_ext, wen_ext, ren_ext, wdata_ext                   IMEM external port
//    addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, rdata_ext_2  DMEM external port
//    enable               CPU run enable
//    busy, done           status (busy outside IDLE, done one cycle at the end)
module cpu_boot_ctrl #(
   parameter int unsigned IMEM_WORDS = 512,
   parameter int unsigned DMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        start,
   input  logic [9:0]  imem_len,
   input  logic [10:0] dmem_len,
   input  logic [31:0] run_cycles,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [31:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [31:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [31:0] wdata_ext_2,
   input  logic [31:0] rdata_ext_2,
   output logic        enable,
   output logic        busy,
   output logic        done
);

   localparam logic [31:0] IMEM_DEPTH = 32'(IMEM_WORDS);
   localparam logic [31:0] DMEM_DEPTH = 32'(DMEM_WORDS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_I = 3'd1,
      LOAD_D = 3'd2,
      RUN    = 3'd3,
`ifdef CPU_BOOT_DUMP_EN
      DUMP   = 3'd4,
`endif
      DONE   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_cnt;
   logic [31:0] r_iLen;
   logic [31:0] r_dLen;
   logic [31:0] r_runCycles;
   logic [31:0] w_iLenSat;
   logic [31:0] w_dLenSat;
   logic        w_cntClr;
   logic        w_cntInc;

`ifdef CPU_BOOT_DUMP_EN
   logic        r_bufFull;
   logic        r_rdPend;
   logic [31:0] r_buf;
`endif

   // Picks the first phase, starting at position 'from' (0=LOAD_I, 1=LOAD_D,
   // 2=RUN, 3=DUMP), whose length or budget is non-zero. Empty phases are
   // skipped in the same transition; if everything is empty we land in DONE.
   function automatic state_t firstPhase(input int from, input logic iNz,
                                         input logic dNz, input logic rNz);
      state_t s;
      s = DONE;
`ifdef CPU_BOOT_DUMP_EN
      if (from <= 3 && dNz) s = DUMP;
`endif
      if (from <= 2 && rNz) s = RUN;
      if (from <= 1 && dNz) s = LOAD_D;
      if (from == 0 && iNz) s = LOAD_I;
      return s;
   endfunction

   assign w_iLenSat = ({22'd0, imem_len} > IMEM_DEPTH) ? IMEM_DEPTH : {22'd0, imem_len};
   assign w_dLenSat = ({21'd0, dmem_len} > DMEM_DEPTH) ? DMEM_DEPTH : {21'd0, dmem_len};

   // The CPU never reads instruction memory through this block.
   assign ren_ext = 1'b0;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) r_state <= IDLE;
      else         r_state <= w_nextState;
   end

   // r_cnt is shared by all phases: beat index while loading, elapsed cycles
   // while running, issued-read index while dumping. It is cleared on every
   // phase exit so each phase starts from 0.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_cnt       <= '0;
         r_iLen      <= '0;
         r_dLen      <= '0;
         r_runCycles <= '0;
      end else begin
         if (r_state == IDLE && start) begin
            r_iLen      <= w_iLenSat;
            r_dLen      <= w_dLenSat;
            r_runCycles <= run_cycles;
         end
         if (w_cntClr)      r_cnt <= '0;
         else if (w_cntInc) r_cnt <= r_cnt + 32'd1;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_cntClr    = 1'b0;
      w_cntInc    = 1'b0;
      in_ready    = 1'b0;
      wen_ext     = 1'b0;
      addr_ext    = '0;
      wdata_ext   = '0;
      wen_ext_2   = 1'b0;
      addr_ext_2  = '0;
      wdata_ext_2 = '0;
`ifdef CPU_BOOT_DUMP_EN
      ren_ext_2   = 1'b0;
`endif
      enable      = 1'b0;
      done        = 1'b0;
      busy        = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (start)
               w_nextState = firstPhase(0, w_iLenSat != 0, w_dLenSat != 0, run_cycles != 0);
         end
         LOAD_I: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wen_ext   = 1'b1;
               addr_ext  = {r_cnt[29:0], 2'b00};
               wdata_ext = in_data;
               if (r_cnt == r_iLen - 32'd1) begin
                  w_nextState = firstPhase(1, 1'b0, r_dLen != 0, r_runCycles != 0);
                  w_cntClr    = 1'b1;
               end else begin
                  w_cntInc = 1'b1;
               end
            end
         end
         LOAD_D: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wen_ext_2   = 1'b1;
               addr_ext_2  = {r_cnt[29:0], 2'b00};
               wdata_ext_2 = in_data;
               if (r_cnt == r_dLen - 32'd1) begin
                  w_nextState = firstPhase(2, 1'b0, r_dLen != 0, r_runCycles != 0);
                  w_cntClr    = 1'b1;
               end else begin
                  w_cntInc = 1'b1;
               end
            end
         end
         RUN: begin
            // Budget is non-zero here (zero budgets skip RUN), so the
            // compare against budget-1 cannot underflow and r_cnt never wraps.
            enable = 1'b1;
            if (r_cnt == r_runCycles - 32'd1) begin
               w_nextState = firstPhase(3, 1'b0, r_dLen != 0, 1'b0);
               w_cntClr    = 1'b1;
            end else begin
               w_cntInc = 1'b1;
            end
         end
`ifdef CPU_BOOT_DUMP_EN
         DUMP: begin
            // One read in flight at most, and only into an empty buffer.
            if (!r_bufFull && !r_rdPend && (r_cnt != r_dLen)) begin
               ren_ext_2  = 1'b1;
               addr_ext_2 = {r_cnt[29:0], 2'b00};
               w_cntInc   = 1'b1;
            end
            // Once every read has been issued, the buffered word is the last.
            if (r_bufFull && out_ready && (r_cnt == r_dLen)) begin
               w_nextState = DONE;
               w_cntClr    = 1'b1;
            end
         end
`endif
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

`ifdef CPU_BOOT_DUMP_EN
   // Read data arrives one cycle after ren_ext_2 and lands in the one-entry
   // output buffer; the buffer drains on a handshake.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_rdPend  <= 1'b0;
         r_bufFull <= 1'b0;
         r_buf     <= '0;
      end else begin
         r_rdPend <= ren_ext_2;
         if (r_rdPend) begin
            r_buf     <= rdata_ext_2;
            r_bufFull <= 1'b1;
         end else if (r_bufFull && out_ready) begin
            r_bufFull <= 1'b0;
         end
      end
   end

   assign out_valid = r_bufFull;
   assign out_data  = r_buf;
`else
   logic w_unusedDumpInputs;
   assign w_unusedDumpInputs = ^{rdata_ext_2, out_ready, DMEM_DEPTH[0]};
   assign out_valid = 1'b0;
   assign out_data  = '0;
   assign ren_ext_2 = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
module tb_cpu_boot_ctrl;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  imem_len = '0;
   logic [10:0] dmem_len = '0;
   logic [31:0] run_cycles = '0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic [31:0] rdata_ext_2 = '0;
   logic        in_ready, out_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic        enable, busy, done;
   logic [31:0] out_data, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;

   always #5 clk = ~clk;

   cpu_boot_ctrl dut (
      .clk(clk), .arst_n(arst_n), .start(start),
      .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
      .enable(enable), .busy(busy), .done(done)
   );

   int passCount = 0;
   int checkCount = 0;
   int sessionId = 0;
   int sessCycles = 0;
   bit timedOut = 1'b0;

   logic [31:0] tbMem [0:1023];
   logic [31:0] stream[$];
   logic [63:0] obsI[$], obsD[$], obsOut[$];
   logic [63:0] expI[$], expD[$], expOut[$];
   int enCycles, enRises, donePulses, gapViol, stallViol, busyViol, portViol;
   int stallCycles, beatIdx, lastId;
   logic [31:0] stallData, prevOut;
   bit prevEn, prevDone, prevStall, prevAccept;

   // Data memory model: 1-cycle read latency on the _2 port.
   always @(posedge clk) begin
      if (wen_ext_2) tbMem[addr_ext_2[11:2]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= tbMem[addr_ext_2[11:2]];
   end

   // Observer: records writes, enable activity, done pulses and dump words,
   // and counts protocol violations, once per cycle away from the clock edge.
   always @(negedge clk) begin
      if (lastId != sessionId) begin
         lastId = sessionId;
         obsI.delete(); obsD.delete(); obsOut.delete();
         enCycles = 0; enRises = 0; donePulses = 0; gapViol = 0; stallViol = 0;
         busyViol = 0; portViol = 0; stallCycles = 0; beatIdx = 0;
         stallData = '0; prevOut = '0;
         prevEn = 0; prevDone = 0; prevStall = 0; prevAccept = 0;
      end
      if (wen_ext)   obsI.push_back({addr_ext, wdata_ext});
      if (wen_ext_2) obsD.push_back({addr_ext_2, wdata_ext_2});
      if ((wen_ext || wen_ext_2) && !in_valid) gapViol++;
      if (in_valid && in_ready) beatIdx++;
      if (enable) enCycles++;
      if (enable && !prevEn) enRises++;
      prevEn = enable;
      if (done) donePulses++;
      if (done && !busy) busyViol++;
      if (prevDone && (busy || done)) busyViol++;
      prevDone = done;
      if (prevStall && (!out_valid || out_data !== prevOut)) stallViol++;
      if (out_valid && !out_ready) begin
         if (stallCycles == 0) stallData = out_data;
         stallCycles++;
      end
      prevStall = out_valid && !out_ready;
      prevOut = out_data;
      if (out_valid && out_ready && prevAccept) stallViol++;
      prevAccept = out_valid && out_ready;
      if (out_valid && out_ready) obsOut.push_back({32'd0, out_data});
      if (ren_ext) portViol++;
      if (!wen_ext && (addr_ext != 0 || wdata_ext != 0)) portViol++;
      if (!wen_ext_2 && !ren_ext_2 && (addr_ext_2 != 0 || wdata_ext_2 != 0)) portViol++;
      if (wen_ext_2 && ren_ext_2) portViol++;
   end

   function automatic int queueDiff(input logic [63:0] a[$], input logic [63:0] b[$]);
      int n;
      n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
      if (a.size() != b.size()) return n;
      return -1;
   endfunction

   function automatic logic [63:0] peek(input logic [63:0] q[$], input int i);
      if (i >= 0 && i < q.size()) return q[i];
      return '1;
   endfunction

   task automatic makeStream(input int n);
      stream.delete();
      for (int i = 0; i < n; i++) stream.push_back($urandom);
   endtask

   // Reference model: IMEM gets the first min(il,512) stream words at 4*k,
   // DMEM the following min(dl,1024) words, and the dump returns those DMEM
   // words in order when the dump feature is built in.
   task automatic buildModel(input int il, input int dl);
      int satI, satD;
      satI = (il > 512) ? 512 : il;
      satD = (dl > 1024) ? 1024 : dl;
      expI.delete(); expD.delete(); expOut.delete();
      for (int k = 0; k < satI; k++) expI.push_back({32'(4 * k), stream[k]});
      for (int k = 0; k < satD; k++) expD.push_back({32'(4 * k), stream[satI + k]});
`ifdef CPU_BOOT_DUMP_EN
      for (int k = 0; k < satD; k++) expOut.push_back({32'd0, stream[satI + k]});
`endif
   endtask

   task automatic runSession(input int il, input int dl, input logic [31:0] rc,
                             input int gapPct, input int readyPct, input int holdoff,
                             input bit noise);
      int holdLeft;
      sessionId++;
      @(negedge clk);
      @(posedge clk); #1;
      start = 1'b1; imem_len = 10'(il); dmem_len = 11'(dl); run_cycles = rc;
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      holdLeft = holdoff;
      sessCycles = 0;
      while (donePulses == 0 && sessCycles < 20000) begin
         start = noise && ($urandom_range(9) == 0);
         if (beatIdx < stream.size() && int'($urandom_range(99)) >= gapPct) begin
            in_valid = 1'b1; in_data = stream[beatIdx];
         end else begin
            in_valid = 1'b0; in_data = $urandom;
         end
         if (holdLeft > 0 && out_valid) begin
            out_ready = 1'b0; holdLeft--;
         end else begin
            out_ready = (int'($urandom_range(99)) < readyPct);
         end
         @(posedge clk); #1;
         sessCycles++;
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      timedOut = (donePulses == 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      arst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
      imem_len = 10'd4; dmem_len = 11'd4; run_cycles = 32'd4;
      repeat (3) @(posedge clk);
      #1;
      checkCount++;
      if ({in_ready, out_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, busy, done} !== 9'b0)
         $display("[TB] FAIL reset_flags: got %b required 0",
                  {in_ready, out_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, busy, done});
      else passCount++;
      checkCount++;
      if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, out_data} !== 160'b0)
         $display("[TB] FAIL reset_buses: got %h required 0",
                  {addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, out_data});
      else passCount++;
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      arst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkCount++;
      if ({busy, in_ready, enable} !== 3'b0)
         $display("[TB] FAIL reset_idle_after_release: got %b required 000", {busy, in_ready, enable});
      else passCount++;
   endtask

   task automatic test_load;
      int d;
      stream = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6};
      runSession(3, 2, 32'd5, 0, 100, 0, 1'b0);
      expI = '{64'h0000_0000_0000_00A0, 64'h0000_0004_0000_00A1, 64'h0000_0008_0000_00A2};
      expD = '{64'h0000_0000_0000_00A3, 64'h0000_0004_0000_00A4};
      d = queueDiff(obsI, expI); checkCount++;
      if (d !== -1) $display("[TB] FAIL load_imem: entry %0d got %h (n=%0d) required %h (n=%0d)",
                             d, peek(obsI, d), obsI.size(), peek(expI, d), expI.size());
      else passCount++;
      d = queueDiff(obsD, expD); checkCount++;
      if (d !== -1) $display("[TB] FAIL load_dmem: entry %0d got %h (n=%0d) required %h (n=%0d)",
                             d, peek(obsD, d), obsD.size(), peek(expD, d), expD.size());
      else passCount++;
      checkCount++;
      if (gapViol !== 0 || portViol !== 0)
         $display("[TB] FAIL load_ports: got gap=%0d port=%0d required 0/0", gapViol, portViol);
      else passCount++;
   endtask

   task automatic test_run;
      stream = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6};
      runSession(3, 2, 32'd5, 0, 100, 0, 1'b0);
      checkCount++;
      if (enCycles !== 5 || enRises !== 1)
         $display("[TB] FAIL run_enable: got cycles=%0d rises=%0d required 5/1", enCycles, enRises);
      else passCount++;
      checkCount++;
      if (donePulses !== 1 || timedOut)
         $display("[TB] FAIL run_done: got pulses=%0d timeout=%0d required 1/0", donePulses, timedOut);
      else passCount++;
      checkCount++;
      if (busyViol !== 0)
         $display("[TB] FAIL run_busy_done: got %0d busy/done violations required 0", busyViol);
      else passCount++;
   endtask

   task automatic test_dump_backpressure;
      int d;
      stream = '{32'h11, 32'h22, 32'h33};
      runSession(0, 2, 32'd1, 0, 100, 4, 1'b0);
      checkCount++;
      if (donePulses !== 1 || timedOut)
         $display("[TB] FAIL dump_done: got pulses=%0d timeout=%0d required 1/0", donePulses, timedOut);
      else passCount++;
`ifdef CPU_BOOT_DUMP_EN
      expOut = '{64'h11, 64'h22};
      d = queueDiff(obsOut, expOut); checkCount++;
      if (d !== -1) $display("[TB] FAIL dump_order: entry %0d got %h (n=%0d) required %h (n=%0d)",
                             d, peek(obsOut, d), obsOut.size(), peek(expOut, d), expOut.size());
      else passCount++;
      checkCount++;
      if (stallCycles !== 4 || stallData !== 32'h11 || stallViol !== 0)
         $display("[TB] FAIL dump_hold: got stall=%0d data=%h viol=%0d required 4/00000011/0",
                  stallCycles, stallData, stallViol);
      else passCount++;
`else
      d = 0;
      checkCount++;
      if (obsOut.size() !== 0 || stallCycles !== d)
         $display("[TB] FAIL dump_absent: got words=%0d valid_stall=%0d required 0/0",
                  obsOut.size(), stallCycles);
      else passCount++;
`endif
   endtask

   task automatic test_zero_lengths;
      stream = '{32'h5};
      runSession(0, 0, 32'd0, 0, 100, 0, 1'b0);
      checkCount++;
      if (obsI.size() !== 0 || obsD.size() !== 0 || enCycles !== 0)
         $display("[TB] FAIL zero_activity: got iw=%0d dw=%0d en=%0d required 0/0/0",
                  obsI.size(), obsD.size(), enCycles);
      else passCount++;
      checkCount++;
      if (donePulses !== 1 || sessCycles > 2)
         $display("[TB] FAIL zero_done: got pulses=%0d latency=%0d required 1/<=2", donePulses, sessCycles);
      else passCount++;
   endtask

   task automatic test_stall;
      int d;
      makeStream(8 + 3 + 4);
      runSession(8, 3, 32'd2, 50, 100, 0, 1'b0);
      buildModel(8, 3);
      d = queueDiff(obsI, expI); checkCount++;
      if (d !== -1) $display("[TB] FAIL stall_imem: entry %0d got %h required %h", d, peek(obsI, d), peek(expI, d));
      else passCount++;
      d = queueDiff(obsD, expD); checkCount++;
      if (d !== -1) $display("[TB] FAIL stall_dmem: entry %0d got %h required %h", d, peek(obsD, d), peek(expD, d));
      else passCount++;
      checkCount++;
      if (gapViol !== 0) $display("[TB] FAIL stall_gap_write: got %0d required 0", gapViol);
      else passCount++;
   endtask

   task automatic test_reset_mid_run;
      int n, d;
      sessionId++;
      @(negedge clk);
      @(posedge clk); #1;
      start = 1'b1; imem_len = 10'd2; dmem_len = 11'd1; run_cycles = 32'd50;
      in_valid = 1'b1; in_data = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!enable && n < 50) begin
         in_data = $urandom;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      checkCount++;
      if (enable !== 1'b1) $display("[TB] FAIL midrun_reach_run: got enable=%b required 1", enable);
      else passCount++;
      repeat (2) @(posedge clk);
      #3;
      arst_n = 1'b0;
      #1;
      checkCount++;
      if (enable !== 1'b0) $display("[TB] FAIL midrun_enable_drop: got %b required 0", enable);
      else passCount++;
      checkCount++;
      if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL midrun_idle: got busy=%b done=%b required 0/0", busy, done);
      else passCount++;
      @(posedge clk); #1;
      arst_n = 1'b1;
      makeStream(1 + 1 + 4);
      runSession(1, 1, 32'd3, 0, 100, 0, 1'b0);
      buildModel(1, 1);
      d = queueDiff(obsI, expI); checkCount++;
      if (d !== -1) $display("[TB] FAIL midrun_restart_load: entry %0d got %h required %h", d, peek(obsI, d), peek(expI, d));
      else passCount++;
      checkCount++;
      if (enCycles !== 3 || donePulses !== 1)
         $display("[TB] FAIL midrun_restart_run: got en=%0d done=%0d required 3/1", enCycles, donePulses);
      else passCount++;
   endtask

   task automatic test_saturation;
      int d;
      makeStream(512 + 1024 + 4);
      runSession(600, 1100, 32'd1, 0, 100, 0, 1'b0);
      buildModel(600, 1100);
      d = queueDiff(obsI, expI); checkCount++;
      if (d !== -1) $display("[TB] FAIL sat_imem: entry %0d got %h (n=%0d) required %h (n=%0d)",
                             d, peek(obsI, d), obsI.size(), peek(expI, d), expI.size());
      else passCount++;
      d = queueDiff(obsD, expD); checkCount++;
      if (d !== -1) $display("[TB] FAIL sat_dmem: entry %0d got %h (n=%0d) required %h (n=%0d)",
                             d, peek(obsD, d), obsD.size(), peek(expD, d), expD.size());
      else passCount++;
      d = queueDiff(obsOut, expOut); checkCount++;
      if (d !== -1) $display("[TB] FAIL sat_dump: entry %0d got %h (n=%0d) required %h (n=%0d)",
                             d, peek(obsOut, d), obsOut.size(), peek(expOut, d), expOut.size());
      else passCount++;
   endtask

   task automatic test_random;
      int il, dl, d, gap, rdy;
      logic [31:0] rc;
      for (int it = 0; it < 6; it++) begin
         il = int'($urandom_range(20));
         dl = int'($urandom_range(20));
         rc = 32'($urandom_range(30));
         gap = int'($urandom_range(60));
         rdy = int'($urandom_range(100, 30));
         makeStream(il + dl + 4);
         runSession(il, dl, rc, gap, rdy, 0, 1'b1);
         buildModel(il, dl);
         d = queueDiff(obsI, expI); checkCount++;
         if (d !== -1) $display("[TB] FAIL rand%0d_imem: entry %0d got %h required %h", it, d, peek(obsI, d), peek(expI, d));
         else passCount++;
         d = queueDiff(obsD, expD); checkCount++;
         if (d !== -1) $display("[TB] FAIL rand%0d_dmem: entry %0d got %h required %h", it, d, peek(obsD, d), peek(expD, d));
         else passCount++;
         d = queueDiff(obsOut, expOut); checkCount++;
         if (d !== -1) $display("[TB] FAIL rand%0d_dump: entry %0d got %h required %h", it, d, peek(obsOut, d), peek(expOut, d));
         else passCount++;
         checkCount++;
         if (enCycles !== int'(rc) || enRises !== ((rc != 0) ? 1 : 0))
            $display("[TB] FAIL rand%0d_enable: got cycles=%0d rises=%0d required %0d/%0d",
                     it, enCycles, enRises, rc, (rc != 0) ? 1 : 0);
         else passCount++;
         checkCount++;
         if (donePulses !== 1 || timedOut || busyViol !== 0)
            $display("[TB] FAIL rand%0d_done: got pulses=%0d timeout=%0d busyviol=%0d required 1/0/0",
                     it, donePulses, timedOut, busyViol);
         else passCount++;
         checkCount++;
         if (gapViol !== 0 || portViol !== 0 || stallViol !== 0)
            $display("[TB] FAIL rand%0d_protocol: got gap=%0d port=%0d stall=%0d required 0/0/0",
                     it, gapViol, portViol, stallViol);
         else passCount++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_load();
      test_run();
      test_dump_backpressure();
      test_zero_lengths();
      test_stall();
      test_reset_mid_run();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
